// File: rtl/tl_a_client_arbiter.sv
// Round-robin arbiter for N L1 Acquire requests; keeps one Acquire in flight to L2 and routes its Grant back.
// Latency: accept at T -> m_a_valid at T+1; m_d_valid sampled at U -> c_d_valid at U+1; next accept at U+2.
// Backpressure: c_a_ready only in IDLE; m_a_valid held until m_a_ready; WAIT_D aborts after TIMEOUT_CYCLES.
module tl_a_client_arbiter #(
    parameter int N_CLIENTS      = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_CLIENTS-1:0]          c_a_valid,
    input  logic [N_CLIENTS-1:0]          c_a_excl,
    input  logic [N_CLIENTS*ADDR_W-1:0]   c_a_addr,
    output logic [N_CLIENTS-1:0]          c_a_ready,
    output logic [N_CLIENTS-1:0]          c_d_valid,
    output logic [DATA_W-1:0]             c_d_data,
    output logic                          c_d_excl,
    output logic                          m_a_valid,
    input  logic                          m_a_ready,
    output logic                          m_a_excl,
    output logic [ADDR_W-1:0]             m_a_addr,
    input  logic                          m_d_valid,
    input  logic [DATA_W-1:0]             m_d_data,
    input  logic                          m_d_excl,
    output logic [$clog2(N_CLIENTS)-1:0]  owner,
    output logic                          busy,
    output logic                          err_timeout
);

    localparam int IDX_W = $clog2(N_CLIENTS);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(N_CLIENTS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef struct packed {
        logic              excl;
        logic [ADDR_W-1:0] addr;
    } req_t;

    typedef struct packed {
        logic              excl;
        logic [DATA_W-1:0] data;
    } gnt_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] owner_q;
    logic [IDX_W-1:0] cand_idx;
    logic [IDX_W-1:0] win_idx;
    logic             win_vld;
    req_t             win_req;
    req_t             req_q;
    gnt_t             gnt_q;
    logic [CNT_W-1:0] cnt;
    logic             err_q;
    logic             accept;
    logic             d_take;
    logic             timeout_hit;

    // Search starts one past the last winner and wraps modulo N_CLIENTS.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        cand_idx = '0;
        for (int k = 0; k < N_CLIENTS; k++) begin
            cand_idx = IDX_W'((int'(rr_ptr) + 1 + k) % N_CLIENTS);
            if (!win_vld && c_a_valid[cand_idx]) begin
                win_vld = 1'b1;
                win_idx = cand_idx;
            end
        end
    end

    always_comb begin
        win_req = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (IDX_W'(i) == win_idx) begin
                win_req.excl = c_a_excl[i];
                win_req.addr = c_a_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign accept = (state == IDLE) && win_vld;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // m_d_valid is only looked at in WAIT_D so a sticky level cannot fake a grant.
    always_comb begin
        state_nxt   = state;
        d_take      = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (win_vld) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (m_a_ready) state_nxt = WAIT_D;
            end
            WAIT_D: begin
                if (m_d_valid) begin
                    d_take    = 1'b1;
                    state_nxt = RESP;
                end else if (cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr  <= PTR_RST;
            owner_q <= '0;
            req_q   <= '0;
            gnt_q   <= '0;
            cnt     <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                rr_ptr  <= win_idx;
                owner_q <= win_idx;
                req_q   <= win_req;
            end
            // Counter is held clear while issuing and saturates rather than wrapping.
            if (state == ISSUE) begin
                cnt <= '0;
            end else if ((state == WAIT_D) && (cnt != {CNT_W{1'b1}})) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (d_take) begin
                gnt_q.excl <= m_d_excl;
                gnt_q.data <= m_d_data;
            end
            err_q <= timeout_hit;
        end
    end

    // Reset gates the combinational accept strobe so every output is low while reset is held.
    always_comb begin
        c_a_ready = '0;
        if (accept && !reset) c_a_ready[win_idx] = 1'b1;
    end

    always_comb begin
        c_d_valid = '0;
        if (state == RESP) c_d_valid[owner_q] = 1'b1;
    end

    assign c_d_data    = gnt_q.data;
    assign c_d_excl    = gnt_q.excl;
    assign m_a_valid   = (state == ISSUE);
    assign m_a_excl    = req_q.excl;
    assign m_a_addr    = req_q.addr;
    assign owner       = owner_q;
    assign busy        = (state != IDLE);
    assign err_timeout = err_q;

endmodule

// File: tb/tb_tl_a_client_arbiter.sv
// Directed bench for tl_a_client_arbiter with two clients and an 8-cycle timeout.
module tb_tl_a_client_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic            clk;
    logic            reset;
    logic [N-1:0]    c_a_valid;
    logic [N-1:0]    c_a_excl;
    logic [N*AW-1:0] c_a_addr;
    logic [N-1:0]    c_a_ready;
    logic [N-1:0]    c_d_valid;
    logic [DW-1:0]   c_d_data;
    logic            c_d_excl;
    logic            m_a_valid;
    logic            m_a_ready;
    logic            m_a_excl;
    logic [AW-1:0]   m_a_addr;
    logic            m_d_valid;
    logic [DW-1:0]   m_d_data;
    logic            m_d_excl;
    logic [0:0]      owner;
    logic            busy;
    logic            err_timeout;

    int n_checks = 0;
    int n_pass   = 0;

    tl_a_client_arbiter #(
        .N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .c_a_valid(c_a_valid), .c_a_excl(c_a_excl), .c_a_addr(c_a_addr),
        .c_a_ready(c_a_ready), .c_d_valid(c_d_valid), .c_d_data(c_d_data),
        .c_d_excl(c_d_excl), .m_a_valid(m_a_valid), .m_a_ready(m_a_ready),
        .m_a_excl(m_a_excl), .m_a_addr(m_a_addr), .m_d_valid(m_d_valid),
        .m_d_data(m_d_data), .m_d_excl(m_d_excl), .owner(owner),
        .busy(busy), .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change and outputs are sampled 2-3 time units after each rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        c_a_valid = '0;
        c_a_excl  = '0;
        c_a_addr  = '0;
        m_a_ready = 1'b1;
        m_d_valid = 1'b0;
        m_d_data  = '0;
        m_d_excl  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_checks++;
        if ({c_a_ready, c_d_valid, m_a_valid, busy, err_timeout, owner} !== 8'b0)
            $display("FAIL reset_strobes: got %b want 0", {c_a_ready, c_d_valid, m_a_valid, busy, err_timeout, owner});
        else n_pass++;
        n_checks++;
        if ({m_a_addr, m_a_excl, c_d_data, c_d_excl} !== 66'b0)
            $display("FAIL reset_data: addr %h data %h, want 0", m_a_addr, c_d_data);
        else n_pass++;
    endtask

    task automatic test_single();
        apply_reset();
        c_a_valid = 2'b01;
        c_a_addr[0 +: AW] = 32'h4;
        #1;
        n_checks++;
        if (c_a_ready !== 2'b01) $display("FAIL single_ready: got %b want 01", c_a_ready);
        else n_pass++;
        step();
        c_a_valid = 2'b00;
        #1;
        n_checks++;
        if (m_a_valid !== 1'b1 || m_a_addr !== 32'h4 || m_a_excl !== 1'b0 || busy !== 1'b1)
            $display("FAIL single_issue: m_a_valid %b addr %h excl %b busy %b want 1 4 0 1", m_a_valid, m_a_addr, m_a_excl, busy);
        else n_pass++;
        step();
        step();
        m_d_valid = 1'b1;
        m_d_data  = 32'hdeadbeef;
        step();
        m_d_valid = 1'b0;
        #1;
        n_checks++;
        if (c_d_valid !== 2'b01 || c_d_data !== 32'hdeadbeef || c_d_excl !== 1'b0)
            $display("FAIL single_grant: c_d_valid %b data %h want 01 deadbeef", c_d_valid, c_d_data);
        else n_pass++;
        step();
        #1;
        n_checks++;
        if (c_d_valid !== 2'b00 || busy !== 1'b0)
            $display("FAIL single_done: c_d_valid %b busy %b want 00 0", c_d_valid, busy);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        apply_reset();
        c_a_valid = 2'b11;
        c_a_excl  = 2'b10;
        c_a_addr[0 +: AW]  = 32'h4;
        c_a_addr[AW +: AW] = 32'h8;
        #1;
        n_checks++;
        if (c_a_ready !== 2'b01) $display("FAIL sim_first_ready: got %b want 01", c_a_ready);
        else n_pass++;
        step();
        c_a_valid = 2'b10;
        #1;
        n_checks++;
        if (owner !== 1'b0 || m_a_addr !== 32'h4 || c_a_ready !== 2'b00)
            $display("FAIL sim_first_issue: owner %0d addr %h ready %b want 0 4 00", owner, m_a_addr, c_a_ready);
        else n_pass++;
        step();
        m_d_valid = 1'b1;
        m_d_data  = 32'h11111111;
        step();
        m_d_valid = 1'b0;
        #1;
        n_checks++;
        if (c_d_valid !== 2'b01 || c_a_ready !== 2'b00)
            $display("FAIL sim_first_grant: c_d_valid %b ready %b want 01 00", c_d_valid, c_a_ready);
        else n_pass++;
        step();
        #1;
        n_checks++;
        if (c_a_ready !== 2'b10) $display("FAIL sim_second_ready: got %b want 10", c_a_ready);
        else n_pass++;
        step();
        c_a_valid = 2'b00;
        #1;
        n_checks++;
        if (owner !== 1'b1 || m_a_addr !== 32'h8 || m_a_excl !== 1'b1)
            $display("FAIL sim_second_issue: owner %0d addr %h excl %b want 1 8 1", owner, m_a_addr, m_a_excl);
        else n_pass++;
        step();
        m_d_valid = 1'b1;
        m_d_data  = 32'hc0ffee00;
        m_d_excl  = 1'b1;
        step();
        m_d_valid = 1'b0;
        m_d_excl  = 1'b0;
        c_a_valid = 2'b11;
        #1;
        n_checks++;
        if (c_d_valid !== 2'b10 || c_d_data !== 32'hc0ffee00 || c_d_excl !== 1'b1 || c_a_ready !== 2'b00)
            $display("FAIL sim_second_grant: c_d_valid %b data %h excl %b ready %b want 10 c0ffee00 1 00",
                     c_d_valid, c_d_data, c_d_excl, c_a_ready);
        else n_pass++;
        step();
        #1;
        n_checks++;
        if (c_a_ready !== 2'b01) $display("FAIL sim_third_ready: got %b want 01", c_a_ready);
        else n_pass++;
        step();
        c_a_valid = 2'b00;
        #1;
        n_checks++;
        if (owner !== 1'b0 || m_a_addr !== 32'h4)
            $display("FAIL sim_third_issue: owner %0d addr %h want 0 4", owner, m_a_addr);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        apply_reset();
        m_a_ready = 1'b0;
        c_a_valid = 2'b10;
        c_a_addr[AW +: AW] = 32'h100;
        step();
        c_a_valid = 2'b00;
        // Stall longer than the timeout to show ISSUE never times out.
        for (int i = 0; i < 10; i++) begin
            #1;
            n_checks++;
            if (m_a_valid !== 1'b1 || m_a_addr !== 32'h100 || err_timeout !== 1'b0)
                $display("FAIL bp_hold_%0d: m_a_valid %b addr %h err %b want 1 100 0", i, m_a_valid, m_a_addr, err_timeout);
            else n_pass++;
            step();
        end
        m_a_ready = 1'b1;
        step();
        #1;
        n_checks++;
        if (m_a_valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL bp_wait: m_a_valid %b busy %b want 0 1", m_a_valid, busy);
        else n_pass++;
        m_d_valid = 1'b1;
        m_d_data  = 32'h12345678;
        step();
        m_d_valid = 1'b0;
        #1;
        n_checks++;
        if (c_d_valid !== 2'b10 || c_d_data !== 32'h12345678 || err_timeout !== 1'b0)
            $display("FAIL bp_grant: c_d_valid %b data %h err %b want 10 12345678 0", c_d_valid, c_d_data, err_timeout);
        else n_pass++;
    endtask

    task automatic test_sticky_d();
        logic [10:0] vld_in;
        logic [10:0] exp_busy;
        logic [21:0] exp_cdv;
        int          pulses;
        vld_in   = 11'b00000111110;
        exp_busy = 11'b00111011100;
        exp_cdv  = {2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
        pulses   = 0;
        apply_reset();
        m_d_valid = 1'b1;
        m_d_data  = 32'haaaa0001;
        c_a_addr[0 +: AW] = 32'h20;
        for (int i = 0; i < 11; i++) begin
            c_a_valid = {1'b0, vld_in[i]};
            #1;
            if (c_d_valid != 2'b00) pulses++;
            n_checks++;
            if (c_d_valid !== exp_cdv[2*i +: 2] || busy !== exp_busy[i])
                $display("FAIL sticky_cyc_%0d: c_d_valid %b busy %b want %b %b", i, c_d_valid, busy, exp_cdv[2*i +: 2], exp_busy[i]);
            else n_pass++;
            step();
        end
        m_d_valid = 1'b0;
        n_checks++;
        if (pulses !== 2) $display("FAIL sticky_pulses: got %0d want 2", pulses);
        else n_pass++;
    endtask

    task automatic test_timeout();
        apply_reset();
        c_a_valid = 2'b01;
        c_a_addr[0 +: AW] = 32'h40;
        step();
        c_a_valid = 2'b00;
        step();
        for (int w = 0; w < TO; w++) begin
            #1;
            n_checks++;
            if (err_timeout !== 1'b0 || busy !== 1'b1 || c_d_valid !== 2'b00)
                $display("FAIL to_wait_%0d: err %b busy %b c_d_valid %b want 0 1 00", w, err_timeout, busy, c_d_valid);
            else n_pass++;
            step();
        end
        #1;
        n_checks++;
        if (err_timeout !== 1'b1 || busy !== 1'b0 || c_d_valid !== 2'b00)
            $display("FAIL to_pulse: err %b busy %b c_d_valid %b want 1 0 00", err_timeout, busy, c_d_valid);
        else n_pass++;
        step();
        #1;
        n_checks++;
        if (err_timeout !== 1'b0) $display("FAIL to_pulse_len: err %b want 0", err_timeout);
        else n_pass++;

        // Grant arriving on the last allowed WAIT_D cycle beats the timeout.
        c_a_valid = 2'b01;
        step();
        c_a_valid = 2'b00;
        step();
        for (int w = 0; w < TO - 1; w++) step();
        m_d_valid = 1'b1;
        m_d_data  = 32'h5a5a5a5a;
        m_d_excl  = 1'b1;
        step();
        m_d_valid = 1'b0;
        m_d_excl  = 1'b0;
        #1;
        n_checks++;
        if (c_d_valid !== 2'b01 || c_d_data !== 32'h5a5a5a5a || c_d_excl !== 1'b1 || err_timeout !== 1'b0)
            $display("FAIL to_race_grant: c_d_valid %b data %h excl %b err %b want 01 5a5a5a5a 1 0",
                     c_d_valid, c_d_data, c_d_excl, err_timeout);
        else n_pass++;
        step();
        #1;
        n_checks++;
        if (err_timeout !== 1'b0 || busy !== 1'b0)
            $display("FAIL to_race_after: err %b busy %b want 0 0", err_timeout, busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        c_a_valid = 2'b01;
        c_a_addr[0 +: AW] = 32'h80;
        step();
        c_a_valid = 2'b00;
        step();
        #1;
        n_checks++;
        if (busy !== 1'b1 || owner !== 1'b0)
            $display("FAIL rst_mid_pre: busy %b owner %0d want 1 0", busy, owner);
        else n_pass++;
        c_a_valid = 2'b11;
        m_d_valid = 1'b1;
        m_d_data  = 32'hffff0000;
        #1;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({c_a_ready, c_d_valid, m_a_valid, busy, err_timeout, owner} !== 8'b0 || m_a_addr !== 32'h0)
            $display("FAIL rst_mid_outputs: strobes %b addr %h want 0 0",
                     {c_a_ready, c_d_valid, m_a_valid, busy, err_timeout, owner}, m_a_addr);
        else n_pass++;
        step();
        reset     = 1'b0;
        m_d_valid = 1'b0;
        #1;
        n_checks++;
        if (c_a_ready !== 2'b01 || c_d_valid !== 2'b00)
            $display("FAIL rst_mid_rr: ready %b c_d_valid %b want 01 00", c_a_ready, c_d_valid);
        else n_pass++;
        step();
        c_a_valid = 2'b00;
        #1;
        n_checks++;
        if (owner !== 1'b0 || m_a_addr !== 32'h80 || c_d_valid !== 2'b00)
            $display("FAIL rst_mid_next: owner %0d addr %h c_d_valid %b want 0 80 00", owner, m_a_addr, c_d_valid);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_backpressure();
        test_sticky_d();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
